// File: rtl/sev_seg_pkg.sv
// ============================================================================
// Module : sev_seg_pkg
// Brief  : Shared types, constants and hex-to-segment decode for the scan driver
// Rev    : 1.0
// ============================================================================
`default_nettype none

package sev_seg_pkg;

  typedef logic [3:0] hex_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low segments, bit order gfedcba
  function automatic logic [6:0] hex7(input hex_t v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sev_seg_hex7.sv
// ============================================================================
// Module : sev_seg_hex7
// Brief  : Combinational hex digit to active-low seven-segment decode
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sev_seg_hex7
  import sev_seg_pkg::*;
(
  input  hex_t       hex,
  output logic [6:0] seg
);

  assign seg = hex7(hex);

endmodule

`default_nettype wire

// File: rtl/sev_seg_scan_driver.sv
// ============================================================================
// Module : sev_seg_scan_driver
// Brief  : Time-multiplexed 7-seg anode scanner with per-slot dead time and
//          frame-synchronous input shadowing. Define SEV_SEG_DIM_EN to add the
//          brightness port (per-slot duty control).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sev_seg_scan_driver
  import sev_seg_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 100_000,
  parameter int DEAD_CYC   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  hex_t [NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0] blank,
`ifdef SEV_SEG_DIM_EN
  input  logic [2:0]            brightness,
`endif
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  frame_start
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DEAD = CNT_W'(DEAD_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  hex_t [NUM_DIGITS-1:0] shadow_digits;
  logic [NUM_DIGITS-1:0] shadow_blank;

  logic                  tick;
  logic                  wrap;
  logic                  in_window;
  hex_t                  cur_digit;
  logic [6:0]            dec_seg;
  logic [6:0]            seg_next;
  logic [NUM_DIGITS-1:0] an_next;

  assign tick      = (cnt == CNT_LAST);
  assign wrap      = tick && (idx == IDX_LAST);
  assign cur_digit = shadow_digits[idx];

  sev_seg_hex7 u_hex7 (
    .hex (cur_digit),
    .seg (dec_seg)
  );

`ifdef SEV_SEG_DIM_EN
  localparam int unsigned LIT_SPAN = SCAN_DIV - DEAD_CYC;

  logic [2:0]  bright_q;
  logic [31:0] lit_end;

  // Duty level is frozen for the whole slot so the window never jumps mid-slot
  always_ff @(posedge clk) begin
    if (reset) begin
      bright_q <= 3'd7;
    end else if (tick) begin
      bright_q <= brightness;
    end
  end

  assign lit_end   = 32'(DEAD_CYC) + ((32'(LIT_SPAN) * (32'(bright_q) + 32'd1)) >> 3);
  assign in_window = (cnt >= CNT_DEAD) && (32'(cnt) < lit_end);
`else
  assign in_window = (cnt >= CNT_DEAD);
`endif

  always_comb begin
    seg_next = SEG_OFF;
    an_next  = '1;
    if (in_window && !shadow_blank[idx]) begin
      an_next  = ~(NUM_DIGITS'(1) << idx);
      seg_next = dec_seg;
    end
  end

  // Shadow starts fully blanked so the first frame after reset stays dark
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt           <= '0;
      idx           <= '0;
      shadow_digits <= '0;
      shadow_blank  <= '1;
      frame_start   <= 1'b0;
      seg           <= SEG_OFF;
      an            <= '1;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) begin
        idx <= wrap ? '0 : idx + 1'b1;
      end
      if (wrap) begin
        shadow_digits <= digits;
        shadow_blank  <= blank;
      end
      frame_start <= wrap;
      seg         <= seg_next;
      an          <= an_next;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sev_seg_scan_driver.sv
// ============================================================================
// Module : tb_sev_seg_scan_driver
// Brief  : Scoreboard bench for sev_seg_scan_driver (SCAN_DIV=8, DEAD_CYC=2)
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_sev_seg_scan_driver;

  localparam int ND = 8;
  localparam int SD = 8;
  localparam int DC = 2;

  localparam logic [6:0] HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       fs;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset;
  logic [7:0][3:0] digits;
  logic [7:0]      blank;
`ifdef SEV_SEG_DIM_EN
  logic [2:0]      brightness;
`endif
  logic [6:0]      seg;
  logic [7:0]      an;
  logic            frame_start;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   bri    = 7;

  sev_seg_scan_driver #(
    .NUM_DIGITS (ND),
    .SCAN_DIV   (SD),
    .DEAD_CYC   (DC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .digits      (digits),
    .blank       (blank),
`ifdef SEV_SEG_DIM_EN
    .brightness  (brightness),
`endif
    .seg         (seg),
    .an          (an),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  // One frame of expected outputs, aligned to the registered output stream
  task automatic push_frame(input logic [31:0] d, input logic [7:0] bl, input int b);
    exp_t e;
    int   lit_n;
    lit_n = ((SD - DC) * (b + 1)) >> 3;
    for (int s = 0; s < ND; s++) begin
      for (int c = 0; c < SD; c++) begin
        e.an  = 8'hFF;
        e.seg = 7'h7F;
        e.fs  = (s == ND - 1) && (c == SD - 1);
        if (!bl[s] && c >= DC && c < DC + lit_n) begin
          e.an  = ~(8'd1 << s);
          e.seg = HEX[d[4*s +: 4]];
        end
        sb.push_back(e);
      end
    end
  endtask

  task automatic run(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $error("FAIL sb_empty observed an=%h seg=%h fs=%b required queued entry", an, seg, frame_start);
      end else begin
        e = sb.pop_front();
        assert ({an, seg, frame_start} === e)
        else begin
          errors++;
          $error("FAIL scan observed an=%h seg=%h fs=%b required an=%h seg=%h fs=%b",
                 an, seg, frame_start, e.an, e.seg, e.fs);
        end
      end
      checks++;
      assert ($countones(~an) <= 1)
      else begin
        errors++;
        $error("FAIL onehot observed an=%h required at most one low", an);
      end
    end
  endtask

  task automatic check_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      checks++;
      assert ({an, seg, frame_start} === {8'hFF, 7'h7F, 1'b0})
      else begin
        errors++;
        $error("FAIL reset observed an=%h seg=%h fs=%b required an=ff seg=7f fs=0",
               an, seg, frame_start);
      end
    end
  endtask

  initial begin
    reset  = 1'b1;
    digits = 32'h76543210;
    blank  = 8'h00;
`ifdef SEV_SEG_DIM_EN
    brightness = 3'd7;
`endif
    @(posedge clk);
    check_reset(3);

    // Dark first frame, then scan order with digits 0..7
    reset = 1'b0;
    push_frame(32'h76543210, 8'hFF, bri);
    push_frame(32'h76543210, 8'h00, bri);
    run(64);
    run(63);

    // Change lands in the cycle of the wrap tick and must still be captured
    digits = 32'h76543213;
    push_frame(32'h76543213, 8'h00, bri);
    run(1);

    // Mid-frame change: current frame keeps 3, next frame shows A
    run(32);
    digits = 32'h7654321A;
    push_frame(32'h7654321A, 8'h00, bri);
    run(32);

    digits = 32'hFFFFFFFF;
    blank  = 8'h02;
    push_frame(32'hFFFFFFFF, 8'h02, bri);
    run(64);
    run(20);

    // Reset mid-slot discards all scan and shadow state
    reset = 1'b1;
    check_reset(2);
    sb.delete();
`ifdef SEV_SEG_DIM_EN
    bri        = 3;
    brightness = 3'd3;
`endif
    reset = 1'b0;
    push_frame(32'hFFFFFFFF, 8'hFF, bri);
    push_frame(32'hFFFFFFFF, 8'h02, bri);
    run(128);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
